uart_rx_param: RTL and testbench

//  Parametrised UART receiver. It oversamples the async rx line and decodes

---
 rtl/uart_rx_param.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. The asynchronous rx line is synchronised, then
// an oversampling FSM validates the start bit at mid-bit and samples every
// following bit (data LSB first, optional parity, 1 or 2 stop bits) one bit
// period later, i.e. always at mid-bit. Each completed frame is presented on
// a valid/ready holding register together with its error flags.
//
// Parameters
//   OVERSAMPLE  clk cycles per bit (even, >= 4)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 none, 1 odd, 2 even
//   STOP_BITS   1 or 2
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       asynchronous active-low reset
//   rx          raw serial line, idle high, asynchronous to clk
//   data        received word, bit 0 = first data bit on the line
//   valid       data/flags hold a frame not yet accepted
//   ready       consumer accepts when valid && ready at posedge
//   parity_err  parity mismatch for the held frame
//   frame_err   a stop bit was sampled low for the held frame
//   overrun     1-cycle pulse: a completed frame was dropped
//   busy        high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic                 stop_idx, stop_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 perr_acc, perr_next;
    logic                 ferr_acc, ferr_next;
    logic                 done;

    logic rx_meta;
    logic rx_s;

    // Two-flop synchroniser; reset to the idle (high) line level so that a
    // line already low at reset release is seen as a fresh falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every flop samples the pre-edge values, whatever the block order.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM and receive datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            shift    <= shift_next;
            perr_acc <= perr_next;
            ferr_acc <= ferr_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_next    = state;
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        shift_next    = shift;
        perr_next     = perr_acc;
        ferr_next     = ferr_acc;
        done          = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end

            S_START: begin
                if (cnt == CNT_MID) begin
                    // Line back high at mid-start: a glitch, not a frame.
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next    = S_DATA;
                        cnt_next      = '0;
                        bit_idx_next  = '0;
                        stop_idx_next = 1'b0;
                        perr_next     = 1'b0;
                        ferr_next     = 1'b0;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    // Shift in from the top so the first bit ends in bit 0.
                    shift_next = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY != 0) state_next = S_PARITY;
                        else             state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                    if (PARITY == 1) perr_next = ~(^{shift, rx_s});
                    else             perr_next = ^{shift, rx_s};
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) ferr_next = 1'b1;
                    // Leave at mid-stop-bit so the next start edge is caught.
                    if (stop_idx == STOP_LAST) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // Output holding register. A completed frame loads when the register is
    // empty or being drained in the same cycle; otherwise it is dropped and
    // overrun pulses. ferr_next carries the final stop sample of this frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data       <= shift;
                    parity_err <= perr_acc;
                    frame_err  <= ferr_next;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Directed bench for uart_rx_param. Three instances share clk and reset:
//   u0 : defaults (8 data bits, no parity, 1 stop)
//   u1 : 8 data bits, even parity, 1 stop
//   u2 : 7 data bits, odd parity, 2 stops
// Frames are driven bit by bit on negedges, OVERSAMPLE clocks per bit. A
// negedge monitor records every accepted frame, valid-high cycles and
// overrun cycles per instance; the directed sequence compares those records
// and the live outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset;

    logic       rx0, rx1, rx2;
    logic       ready0, ready1, ready2;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic       valid0, valid1, valid2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       ovr0, ovr1, ovr2;
    logic       busy0, busy1, busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_param u0 (
        .clk(clk), .reset(reset), .rx(rx0), .data(data0), .valid(valid0),
        .ready(ready0), .parity_err(perr0), .frame_err(ferr0),
        .overrun(ovr0), .busy(busy0)
    );

    uart_rx_param #(.PARITY(2)) u1 (
        .clk(clk), .reset(reset), .rx(rx1), .data(data1), .valid(valid1),
        .ready(ready1), .parity_err(perr1), .frame_err(ferr1),
        .overrun(ovr1), .busy(busy1)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .rx(rx2), .data(data2), .valid(valid2),
        .ready(ready2), .parity_err(perr2), .frame_err(ferr2),
        .overrun(ovr2), .busy(busy2)
    );

    // Per-instance records of what the consumer side observed.
    int         acc_n [3] = '{default: 0};
    logic [8:0] acc_d [3] = '{default: '0};
    logic       acc_pe[3] = '{default: 1'b0};
    logic       acc_fe[3] = '{default: 1'b0};
    int         vcyc  [3] = '{default: 0};
    int         ocyc  [3] = '{default: 0};

    always @(negedge clk) begin
        if (valid0) vcyc[0] <= vcyc[0] + 1;
        if (valid1) vcyc[1] <= vcyc[1] + 1;
        if (valid2) vcyc[2] <= vcyc[2] + 1;
        if (ovr0)   ocyc[0] <= ocyc[0] + 1;
        if (ovr1)   ocyc[1] <= ocyc[1] + 1;
        if (ovr2)   ocyc[2] <= ocyc[2] + 1;
        if (valid0 && ready0) begin
            acc_n[0] <= acc_n[0] + 1;  acc_d[0]  <= 9'(data0);
            acc_pe[0] <= perr0;        acc_fe[0] <= ferr0;
        end
        if (valid1 && ready1) begin
            acc_n[1] <= acc_n[1] + 1;  acc_d[1]  <= 9'(data1);
            acc_pe[1] <= perr1;        acc_fe[1] <= ferr1;
        end
        if (valid2 && ready2) begin
            acc_n[2] <= acc_n[2] + 1;  acc_d[2]  <= 9'(data2);
            acc_pe[2] <= perr2;        acc_fe[2] <= ferr2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic b);
        case (which)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    // Drive n bits (bit 0 first) on one line, one bit period each.
    task automatic send(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(which, bits[i]);
            repeat (OS) @(negedge clk);
        end
    endtask

    task automatic idle(input int which, input int nbits);
        set_rx(which, 1'b1);
        repeat (OS * nbits) @(negedge clk);
    endtask

    int n_acc, n_v, n_o;

    initial begin
        reset  = 1'b0;
        rx0    = 1'b1;  rx1    = 1'b1;  rx2    = 1'b1;
        ready0 = 1'b1;  ready1 = 1'b1;  ready2 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_data0",  32'(data0),  32'h0);
        check("rst_valid0", 32'(valid0), 32'h0);
        check("rst_busy0",  32'(busy0),  32'h0);
        check("rst_flags0", 32'({perr0, ferr0, ovr0}), 32'h0);
        check("rst_valid2", 32'(valid2), 32'h0);

        reset = 1'b1;
        repeat (32) @(negedge clk);

        // 1) 0x55, 8N1, ready=1: delivered once, valid for one cycle.
        n_acc = acc_n[0];  n_v = vcyc[0];  n_o = ocyc[0];
        send(0, 16'({1'b1, 8'h55, 1'b0}), 10);
        idle(0, 2);
        check("t1_count", 32'(acc_n[0] - n_acc), 32'd1);
        check("t1_data",  32'(acc_d[0]), 32'h55);
        check("t1_flags", 32'({acc_pe[0], acc_fe[0]}), 32'h0);
        check("t1_vcyc",  32'(vcyc[0] - n_v), 32'd1);
        check("t1_ovr",   32'(ocyc[0] - n_o), 32'd0);
        check("t1_busy",  32'(busy0), 32'h0);

        // 2) 4-clock low glitch: start rejected, nothing delivered.
        n_v = vcyc[0];
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_busy_hi", 32'(busy0), 32'h1);
        rx0 = 1'b1;
        repeat (30) @(negedge clk);
        check("t2_busy_lo", 32'(busy0), 32'h0);
        check("t2_novalid", 32'(vcyc[0] - n_v), 32'd0);

        // 3) Even parity, 0xA3 has four ones: parity bit 1 is wrong, 0 is right.
        n_acc = acc_n[1];
        send(1, 16'({1'b1, 1'b1, 8'hA3, 1'b0}), 11);
        idle(1, 2);
        check("t3_bad_data", 32'(acc_d[1]), 32'hA3);
        check("t3_bad_perr", 32'(acc_pe[1]), 32'h1);
        check("t3_bad_ferr", 32'(acc_fe[1]), 32'h0);
        send(1, 16'({1'b1, 1'b0, 8'hA3, 1'b0}), 11);
        idle(1, 2);
        check("t3_good_data", 32'(acc_d[1]), 32'hA3);
        check("t3_good_perr", 32'(acc_pe[1]), 32'h0);
        check("t3_count",     32'(acc_n[1] - n_acc), 32'd2);

        // 4) Stop bit low -> frame_err; next clean frame has clean flags.
        n_acc = acc_n[0];
        send(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
        idle(0, 3);
        check("t4_err_data", 32'(acc_d[0]), 32'h3C);
        check("t4_err_ferr", 32'(acc_fe[0]), 32'h1);
        check("t4_err_perr", 32'(acc_pe[0]), 32'h0);
        send(0, 16'({1'b1, 8'h81, 1'b0}), 10);
        idle(0, 2);
        check("t4_ok_data",  32'(acc_d[0]), 32'h81);
        check("t4_ok_flags", 32'({acc_pe[0], acc_fe[0]}), 32'h0);
        check("t4_count",    32'(acc_n[0] - n_acc), 32'd2);

        // 5) ready=0: second frame dropped with a single overrun cycle.
        @(negedge clk);
        #1 ready0 = 1'b0;
        n_acc = acc_n[0];  n_o = ocyc[0];
        repeat (OS) @(negedge clk);
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        idle(0, 2);
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        idle(0, 2);
        check("t5_ovr_cyc", 32'(ocyc[0] - n_o), 32'd1);
        check("t5_valid",   32'(valid0), 32'h1);
        check("t5_data",    32'(data0),  32'h11);
        check("t5_no_acc",  32'(acc_n[0] - n_acc), 32'd0);
        #1 ready0 = 1'b1;
        @(negedge clk);
        check("t5_drained", 32'(valid0), 32'h0);
        check("t5_hold",    32'(data0),  32'h11);

        // 6) 7O2: reset mid-data loses the partial frame; clean 0x5A after.
        // 0x5A (7 bits) has four ones, so the odd parity bit is 1.
        n_acc = acc_n[2];
        send(2, 16'({1'b1, 1'b1, 1'b1, 1'b0}), 4);
        check("t6_busy_mid", 32'(busy2), 32'h1);
        reset = 1'b0;
        rx2   = 1'b1;
        #1;
        check("t6_rst_busy",  32'(busy2),  32'h0);
        check("t6_rst_valid", 32'(valid2), 32'h0);
        check("t6_rst_data",  32'(data2),  32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(2, 3);
        check("t6_idle", 32'(busy2), 32'h0);
        send(2, 16'({1'b1, 1'b1, 1'b1, 7'h5A, 1'b0}), 11);
        idle(2, 2);
        check("t6_data",  32'(acc_d[2]), 32'h5A);
        check("t6_flags", 32'({acc_pe[2], acc_fe[2]}), 32'h0);
        check("t6_count", 32'(acc_n[2] - n_acc), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
